// File: rtl/system_memory_pkg.sv
// Shared types for the system grid memory: the effective-mode encoding and
// the RUN > LOAD > OUTPUT > HOLD priority decode.
package system_memory_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_RUN,
    MODE_LOAD,
    MODE_OUTPUT
  } mem_mode_t;

  function automatic mem_mode_t decode_mode(input logic run, input logic load, input logic unload);
    if (run)    return MODE_RUN;
    if (load)   return MODE_LOAD;
    if (unload) return MODE_OUTPUT;
    return MODE_HOLD;
  endfunction

endpackage

// File: rtl/system_memory_v5_beat_counter.sv
// Frame beat counter. LAST flags the beat that completes a frame; a beat taken
// while CLEAR is high counts as beat 0 of a fresh frame.
module BEAT_COUNTER #(
  parameter int BEATS = 25
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         CLEAR,
  input  logic                         STEP,
  output logic [$clog2(BEATS+1)-1:0]   COUNT,
  output logic                         LAST
);

  localparam int W = $clog2(BEATS + 1);
  localparam logic [W-1:0] FINAL_BEAT = W'(BEATS - 1);

  assign LAST = CLEAR ? (BEATS == 1) : (COUNT == FINAL_BEAT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
    end else if (STEP) begin
      if (LAST)       COUNT <= '0;
      else if (CLEAR) COUNT <= W'(1);
      else            COUNT <= COUNT + W'(1);
    end else if (CLEAR) begin
      COUNT <= '0;
    end
  end

endmodule

// File: rtl/system_memory_v5.sv
// Grid cell store: parallel capture from the next-state logic, serial load,
// and rotating serial unload with frame-complete and output-valid strobes.
module system_memory_v5
  import system_memory_pkg::*;
#(
  parameter int DATA_SIZE = 25,
  parameter int LANES     = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [DATA_SIZE-1:0] GRID_IN,
  input  logic [LANES-1:0]     SERIAL_IN,
  input  logic                 LOAD_MODE,
  input  logic                 RUN_MODE,
  input  logic                 OUTPUT_MODE,
  output logic [DATA_SIZE-1:0] SYSTEM_MEM_OUT,
  output logic [LANES-1:0]     SERIAL_OUT,
  output logic                 OUT_VALID,
  output logic                 FRAME_DONE
);

  localparam int BEATS = DATA_SIZE / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  generate
    if (LANES < 1 || LANES > DATA_SIZE || (DATA_SIZE % LANES) != 0) begin : g_bad_params
      $error("system_memory_v5: DATA_SIZE must be a positive multiple of LANES");
    end
  endgenerate

  mem_mode_t            mode;
  mem_mode_t            prev_mode;
  logic [DATA_SIZE-1:0] mem;
  logic [DATA_SIZE-1:0] load_next;
  logic [DATA_SIZE-1:0] rot_next;
  logic                 step;
  logic                 switch_mode;
  logic                 clear;
  logic                 last;
  logic [CW-1:0]        beat_count;

  assign mode        = decode_mode(RUN_MODE, LOAD_MODE, OUTPUT_MODE);
  assign step        = (mode == MODE_LOAD) || (mode == MODE_OUTPUT);
  // A direct LOAD<->OUTPUT change restarts the frame count at this beat.
  assign switch_mode = ((mode == MODE_LOAD)   && (prev_mode == MODE_OUTPUT)) ||
                       ((mode == MODE_OUTPUT) && (prev_mode == MODE_LOAD));
  assign clear       = !step || switch_mode;

  generate
    if (LANES == DATA_SIZE) begin : g_full_width
      assign load_next = SERIAL_IN;
      assign rot_next  = mem;
    end else begin : g_shift
      assign load_next = {mem[DATA_SIZE-LANES-1:0], SERIAL_IN};
      assign rot_next  = {mem[DATA_SIZE-LANES-1:0], mem[DATA_SIZE-1 -: LANES]};
    end
  endgenerate

  BEAT_COUNTER #(.BEATS(BEATS)) u_beat_counter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLEAR   (clear),
    .STEP    (step),
    .COUNT   (beat_count),
    .LAST    (last)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem        <= '0;
      SERIAL_OUT <= '0;
      OUT_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      prev_mode  <= MODE_HOLD;
    end else begin
      prev_mode  <= mode;
      FRAME_DONE <= step && last;
      SERIAL_OUT <= '0;
      OUT_VALID  <= 1'b0;
      case (mode)
        MODE_RUN:  mem <= GRID_IN;
        MODE_LOAD: mem <= load_next;
        MODE_OUTPUT: begin
          SERIAL_OUT <= mem[DATA_SIZE-1 -: LANES];
          mem        <= rot_next;
          OUT_VALID  <= 1'b1;
        end
        default:   mem <= mem;
      endcase
    end
  end

  assign SYSTEM_MEM_OUT = mem;

  beat_count_in_range: assert property (@(posedge CLK) disable iff (!RESET_N) int'(beat_count) < BEATS);

endmodule

// File: tb/tb_system_memory_v5.sv
// Scoreboard bench: two memory configurations (6x2 and 5x1) share mode inputs and
// are checked every cycle against a bit-queue reference model of the cell store.
module tb_system_memory_v5;

  typedef struct {
    int          cyc;
    logic [63:0] mem;
    logic [63:0] sout;
    logic        valid;
    logic        done;
  } exp_rec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       runMode = 1'b0, loadMode = 1'b0, outMode = 1'b0;
  logic [5:0] grid6 = '0, mem6;
  logic [1:0] sin6 = '0, sout6;
  logic       valid6, done6;
  logic [4:0] grid5 = '0, mem5;
  logic [0:0] sin5 = '0, sout5;
  logic       valid5, done5;

  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;
  exp_rec_t sb6[$];
  exp_rec_t sb5[$];

  logic [63:0] mMem6 = '0, mMem5 = '0;
  int mFrame6 = 0, mFrame5 = 0, mBeats6 = 0, mBeats5 = 0;

  system_memory_v5 #(.DATA_SIZE(6), .LANES(2)) dut6 (
    .CLK(clk), .RESET_N(rstN), .GRID_IN(grid6), .SERIAL_IN(sin6),
    .LOAD_MODE(loadMode), .RUN_MODE(runMode), .OUTPUT_MODE(outMode),
    .SYSTEM_MEM_OUT(mem6), .SERIAL_OUT(sout6), .OUT_VALID(valid6), .FRAME_DONE(done6)
  );

  system_memory_v5 #(.DATA_SIZE(5), .LANES(1)) dut5 (
    .CLK(clk), .RESET_N(rstN), .GRID_IN(grid5), .SERIAL_IN(sin5),
    .LOAD_MODE(loadMode), .RUN_MODE(runMode), .OUTPUT_MODE(outMode),
    .SYSTEM_MEM_OUT(mem5), .SERIAL_OUT(sout5), .OUT_VALID(valid5), .FRAME_DONE(done5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: cells held as a queue, earliest (MSB) cell at the front.
  task automatic modelStep(input int size, input int lanes, input int mode,
                           input logic [63:0] grid, input logic [63:0] sin,
                           inout logic [63:0] mem, inout int frameMode, inout int beats,
                           output exp_rec_t e);
    bit cells[$];
    bit b;
    e.cyc = 0; e.sout = '0; e.valid = 1'b0; e.done = 1'b0;
    for (int i = size - 1; i >= 0; i--) cells.push_back(mem[i]);
    if (mode == 1) begin
      cells.delete();
      for (int i = size - 1; i >= 0; i--) cells.push_back(grid[i]);
      frameMode = 0; beats = 0;
    end else if (mode == 2 || mode == 3) begin
      if (frameMode != mode) begin
        frameMode = mode; beats = 0;
      end
      for (int j = lanes - 1; j >= 0; j--) begin
        b = cells.pop_front();
        if (mode == 3) begin
          e.sout[j] = b;
          cells.push_back(b);
        end else begin
          cells.push_back(sin[j]);
        end
      end
      e.valid = (mode == 3);
      beats++;
      if (beats == size / lanes) begin
        e.done = 1'b1; beats = 0;
      end
    end else begin
      frameMode = 0; beats = 0;
    end
    mem = '0;
    for (int i = 0; i < size; i++) mem[size-1-i] = cells[i];
    e.mem = mem;
  endtask

  task automatic applyStimulus(input logic run, input logic load, input logic outReq,
                               input logic [5:0] g6, input logic [1:0] s6,
                               input logic [4:0] g5, input logic [0:0] s5);
    int mode;
    exp_rec_t e;
    @(posedge clk);
    #1;
    runMode = run; loadMode = load; outMode = outReq;
    grid6 = g6; sin6 = s6; grid5 = g5; sin5 = s5;
    mode = run ? 1 : load ? 2 : outReq ? 3 : 0;
    modelStep(6, 2, mode, 64'(g6), 64'(s6), mMem6, mFrame6, mBeats6, e);
    e.cyc = cyc + 1;
    sb6.push_back(e);
    modelStep(5, 1, mode, 64'(g5), 64'(s5), mMem5, mFrame5, mBeats5, e);
    e.cyc = cyc + 1;
    sb5.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem6"},   64'(mem6),   '0);
    checkOutput({tag, " sout6"},  64'(sout6),  '0);
    checkOutput({tag, " valid6"}, 64'(valid6), '0);
    checkOutput({tag, " done6"},  64'(done6),  '0);
    checkOutput({tag, " mem5"},   64'(mem5),   '0);
    checkOutput({tag, " sout5"},  64'(sout5),  '0);
    checkOutput({tag, " valid5"}, 64'(valid5), '0);
    checkOutput({tag, " done5"},  64'(done5),  '0);
  endtask

  // Reset lands between edges, after the last scheduled beat has been compared.
  task automatic resetPulse();
    @(posedge clk);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    runMode = 1'b0; loadMode = 1'b0; outMode = 1'b0;
    #1;
    checkAllZero("async reset");
    mMem6 = '0; mMem5 = '0;
    mFrame6 = 0; mFrame5 = 0; mBeats6 = 0; mBeats5 = 0;
    #1;
    rstN = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      while (sb6.size() > 0 && sb6[0].cyc < cyc) begin
        checkOutput("stale6", 64'(sb6[0].cyc), 64'(cyc));
        void'(sb6.pop_front());
      end
      while (sb5.size() > 0 && sb5[0].cyc < cyc) begin
        checkOutput("stale5", 64'(sb5[0].cyc), 64'(cyc));
        void'(sb5.pop_front());
      end
      if (sb6.size() > 0 && sb6[0].cyc == cyc) begin
        exp_rec_t e;
        e = sb6.pop_front();
        checkOutput("mem6",   64'(mem6),   e.mem);
        checkOutput("sout6",  64'(sout6),  e.sout);
        checkOutput("valid6", 64'(valid6), 64'(e.valid));
        checkOutput("done6",  64'(done6),  64'(e.done));
      end
      if (sb5.size() > 0 && sb5[0].cyc == cyc) begin
        exp_rec_t e;
        e = sb5.pop_front();
        checkOutput("mem5",   64'(mem5),   e.mem);
        checkOutput("sout5",  64'(sout5),  e.sout);
        checkOutput("valid5", 64'(valid5), 64'(e.valid));
        checkOutput("done5",  64'(done5),  64'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;

    // Serial load of 100111 into the 6x2 store, then unload it back out.
    applyStimulus(0, 1, 0, '0, 2'b10, '0, 1'b1);
    applyStimulus(0, 1, 0, '0, 2'b01, '0, 1'b0);
    applyStimulus(0, 1, 0, '0, 2'b11, '0, 1'b1);
    repeat (3) applyStimulus(0, 0, 1, '0, '0, '0, '0);

    applyStimulus(1, 1, 1, 6'b110011, 2'b00, 5'b10101, 1'b0);
    applyStimulus(0, 1, 1, '0, 2'b01, '0, 1'b1);
    applyStimulus(0, 0, 0, '0, '0, '0, '0);

    repeat (2) applyStimulus(0, 0, 1, '0, '0, '0, '0);
    repeat (3) applyStimulus(0, 1, 0, '0, 2'($urandom_range(0, 3)), '0, 1'($urandom_range(0, 1)));

    applyStimulus(0, 0, 1, '0, '0, '0, '0);
    applyStimulus(0, 0, 1, '0, '0, '0, '0);
    resetPulse();
    repeat (3) applyStimulus(0, 0, 1, '0, '0, '0, '0);

    // 01101 in the 5x1 store, then streamed continuously for three frames.
    applyStimulus(1, 0, 0, 6'b101100, '0, 5'b01101, '0);
    repeat (15) applyStimulus(0, 0, 1, '0, '0, '0, '0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) resetPulse();
      applyStimulus(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
    end

    applyStimulus(0, 0, 0, '0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("drain6", 64'(sb6.size()), 64'd0);
    checkOutput("drain5", 64'(sb5.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
